// File: rtl/sha256_stream_core.sv
// Handshaked multi-block SHA-256 engine: pads a runtime-length message internally and
// compresses each 512-bit block one round per cycle, chaining H across blocks.
module sha256_stream_core #(
  parameter int MSG_BITS = 96,
  parameter int LEN_W    = $clog2(MSG_BITS+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MSG_BITS-1:0] message,
  input  logic [LEN_W-1:0]    msg_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [255:0]        H_out,
  output logic                busy
);
  localparam int MAX_BLOCKS = (MSG_BITS + 65 + 511) / 512;
  localparam int PAD_BITS   = MAX_BLOCKS * 512;
  localparam int BLK_W      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [PAD_BITS-1:0] ONE = PAD_BITS'(1);

  localparam logic [0:7][31:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  state_t               state_q, state_d;
  logic [MSG_BITS-1:0]  msg_q;
  logic [LEN_W-1:0]     len_q, len_sat;
  logic [BLK_W-1:0]     blk_q;
  logic [5:0]           t_q;
  logic [0:7][31:0]     h_q, v_q;   // v_q = working vars a..h
  logic [0:15][31:0]    w_q;        // w_q[0] is W[t]
  logic [31:0]          last_blk, t1, t2, w_new;
  logic                 is_last;
  logic [MSG_BITS-1:0]  msg_mask;
  logic [PAD_BITS-1:0]  pad;
  logic [511:0]         blk_data;

  assign len_sat  = (msg_len > LEN_W'(MSG_BITS)) ? LEN_W'(MSG_BITS) : msg_len;
  assign last_blk = ((32'(len_q) + 32'd576) >> 9) - 32'd1;
  assign is_last  = (32'(blk_q) == last_blk);
  assign H_out    = h_q;

  // Padded message image; the length field lands at the tail of the last live block,
  // not necessarily at the tail of the whole vector.
  always_comb begin
    msg_mask = ~({MSG_BITS{1'b1}} >> len_q);
    pad      = {msg_q & msg_mask, {(PAD_BITS-MSG_BITS){1'b0}}};
    pad      = pad | (ONE << (PAD_BITS - 1 - int'(len_q)));
    pad      = pad | ({{(PAD_BITS-64){1'b0}}, 64'(len_q)} << ((32'(MAX_BLOCKS-1) - last_blk) << 9));
    blk_data = pad[PAD_BITS-1 -: 512];
    for (int b = 1; b < MAX_BLOCKS; b++)
      if (32'(blk_q) == 32'(b)) blk_data = pad[PAD_BITS-1-b*512 -: 512];
  end

  always_comb begin
    t1    = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[t_q] + w_q[0];
    t2    = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (t_q == 6'd63) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy    = 1'b1;
        state_d = is_last ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_q <= '0;
      len_q <= '0;
      blk_q <= '0;
      t_q   <= '0;
      h_q   <= H0;
      v_q   <= '0;
      w_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          msg_q <= message;
          len_q <= len_sat;
          h_q   <= H0;
          blk_q <= '0;
        end
        S_LOAD: begin
          w_q <= blk_data;
          v_q <= h_q;
          t_q <= '0;
        end
        S_ROUND: begin
          v_q <= {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
          w_q <= {w_q[1:15], w_new};
          t_q <= t_q + 6'd1;
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
          if (!is_last) blk_q <= blk_q + BLK_W'(1);
        end
        S_DONE: if (out_ready) blk_q <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: a 96-bit and a 512-bit instance checked against a
// straightforward bit-array SHA-256 model, plus the published digests.
module tb_sha256_stream_core;
  logic         clk = 0, rst = 1;
  logic         in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
  logic [95:0]  message = '0;
  logic [6:0]   msg_len = '0;
  logic [255:0] h_out;
  logic         in_valid_b = 0, out_ready_b = 0, in_ready_b, out_valid_b, busy_b;
  logic [511:0] message_b = '0;
  logic [9:0]   msg_len_b = '0;
  logic [255:0] h_out_b;
  int tests = 0, fails = 0;

  localparam logic [255:0] H0_TB  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_NULL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_448  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_stream_core #(.MSG_BITS(96)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .message(message),
    .msg_len(msg_len), .out_valid(out_valid), .out_ready(out_ready), .H_out(h_out), .busy(busy));

  sha256_stream_core #(.MSG_BITS(512)) dut512 (
    .clk(clk), .reset(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .message(message_b),
    .msg_len(msg_len_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .H_out(h_out_b), .busy(busy_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: explicit padded bit array, full 64-word schedule per block.
  function automatic logic [255:0] sha_ref(input logic [1023:0] msg, input int len);
    bit p [0:1535];
    logic [31:0] hh [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [255:0] hv;
    int nb;
    nb = (len + 65 + 511) / 512;
    hv = H0_TB;
    for (int i = 0; i < 8; i++) hh[i] = hv[255-32*i -: 32];
    for (int i = 0; i < 1536; i++) p[i] = (i < len) ? msg[1023-i] : 1'b0;
    p[len] = 1'b1;
    for (int j = 0; j < 64; j++) p[nb*512-1-j] = bit'((len >> j) & 1);
    for (int bk = 0; bk < nb; bk++) begin
      for (int t = 0; t < 16; t++) begin
        w[t] = 0;
        for (int k = 0; k < 32; k++) w[t] = {w[t][30:0], p[bk*512 + t*32 + k]};
      end
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d; hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drivers (no checking); all start and end #1 after a rising edge.
  task automatic start_a(input logic [95:0] m, input logic [6:0] l);
    in_valid = 1; message = m; msg_len = l;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_a(input bit noise, output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      if (noise) begin in_valid = 1'($urandom); message = rnd96(); msg_len = 7'($urandom); end
      @(posedge clk); #1; lat++;
    end
    in_valid = 0;
  endtask

  task automatic ack_a();
    out_ready = 1; @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic run_b(input logic [511:0] m, input logic [9:0] l, output logic [255:0] d, output int lat);
    in_valid_b = 1; message_b = m; msg_len_b = l;
    @(posedge clk); #1;
    in_valid_b = 0; message_b = '1; lat = 0;
    while (!out_valid_b && lat < 400) begin @(posedge clk); #1; lat++; end
    d = h_out_b;
    out_ready_b = 1; @(posedge clk); #1; out_ready_b = 0;
  endtask

  task automatic test_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (h_out !== H0_TB) begin fails++; $display("FAIL reset_h_out: got %h want %h", h_out, H0_TB); end
    tests++; if (h_out_b !== H0_TB) begin fails++; $display("FAIL reset_h_out_512: got %h want %h", h_out_b, H0_TB); end
  endtask

  task automatic test_known();
    int lat;
    start_a({24'h616263, 32'($urandom), 40'($urandom)}, 7'd24); wait_a(1'b0, lat);
    tests++; if (lat !== 66) begin fails++; $display("FAIL abc_latency: got %0d want 66", lat); end
    tests++; if (h_out !== D_ABC) begin fails++; $display("FAIL abc_digest: got %h want %h", h_out, D_ABC); end
    ack_a();
    start_a(rnd96(), 7'd0); wait_a(1'b0, lat);
    tests++; if (lat !== 66) begin fails++; $display("FAIL empty_latency: got %0d want 66", lat); end
    tests++; if (h_out !== D_NULL) begin fails++; $display("FAIL empty_digest: got %h want %h", h_out, D_NULL); end
    ack_a();
  endtask

  task automatic test_random();
    logic [95:0] m; int l, lat; logic [255:0] exp;
    for (int i = 0; i < 10; i++) begin
      m = rnd96(); l = (i == 0) ? 96 : $urandom_range(0, 96);
      exp = sha_ref({m, 928'b0}, l);
      start_a(m, 7'(l)); wait_a(1'b1, lat);
      tests++; if (lat !== 66) begin fails++; $display("FAIL rand_latency len=%0d: got %0d want 66", l, lat); end
      tests++; if (h_out !== exp) begin fails++; $display("FAIL rand_digest len=%0d: got %h want %h", l, h_out, exp); end
      ack_a();
    end
  endtask

  task automatic test_saturate();
    logic [95:0] m; logic [6:0] l; int lat; logic [255:0] exp;
    for (int i = 0; i < 3; i++) begin
      m = rnd96(); l = (i == 0) ? 7'd127 : (i == 1) ? 7'd97 : 7'($urandom_range(98, 126));
      exp = sha_ref({m, 928'b0}, 96);
      start_a(m, l); wait_a(1'b0, lat);
      tests++; if (h_out !== exp) begin fails++; $display("FAIL sat_digest len=%0d: got %h want %h", l, h_out, exp); end
      ack_a();
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] m; int l, lat; logic [255:0] exp;
    m = rnd96(); l = $urandom_range(0, 96); exp = sha_ref({m, 928'b0}, l);
    start_a(m, 7'(l)); wait_a(1'b1, lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; message = rnd96(); msg_len = 7'($urandom);
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || h_out !== exp) begin
        fails++; $display("FAIL bp_hold cyc=%0d: got ov=%b ir=%b %h want ov=1 ir=0 %h", i, out_valid, in_ready, h_out, exp);
      end
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || h_out !== exp) begin
      fails++; $display("FAIL bp_no_capture: got busy=%b %h want busy=0 %h", busy, h_out, exp); end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_a(rnd96(), 7'd80);
    repeat (31) begin @(posedge clk); #1; end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 rst = 1; #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || h_out !== H0_TB) begin
      fails++; $display("FAIL mid_reset: got busy=%b ir=%b ov=%b %h", busy, in_ready, out_valid, h_out); end
    #1 rst = 0;
    @(posedge clk); #1;
    start_a({24'h616263, 72'h0}, 7'd24); wait_a(1'b0, lat);
    tests++; if (lat !== 66 || h_out !== D_ABC) begin
      fails++; $display("FAIL post_reset_abc: got lat=%0d %h want 66 %h", lat, h_out, D_ABC); end
    ack_a();
  endtask

  task automatic test_back_to_back();
    logic [95:0] m; int l, lat; logic [255:0] exp;
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      m = rnd96(); l = $urandom_range(0, 96); exp = sha_ref({m, 928'b0}, l);
      in_valid = 1; message = m; msg_len = 7'(l);
      @(posedge clk); #1; in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
      tests++; if (lat !== 66 || h_out !== exp) begin
        fails++; $display("FAIL b2b_%0d: got lat=%0d %h want 66 %h", i, lat, h_out, exp); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_pulse_%0d: got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready); end
    end
    out_ready = 0;
  endtask

  task automatic test_multiblock();
    logic [447:0] s; logic [511:0] m; int lat, l; logic [255:0] d, exp;
    int lens [7] = '{448, 0, 447, 448, 511, 512, 300};
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    run_b({s, 32'($urandom), 32'($urandom)}, 10'd448, d, lat);
    tests++; if (lat !== 132) begin fails++; $display("FAIL mb448_latency: got %0d want 132", lat); end
    tests++; if (d !== D_448) begin fails++; $display("FAIL mb448_digest: got %h want %h", d, D_448); end
    for (int i = 1; i < 8; i++) begin
      for (int k = 0; k < 16; k++) m[k*32 +: 32] = $urandom;
      l = (i < 7) ? lens[i] : 512;
      exp = sha_ref({m, 512'b0}, l);
      run_b(m, (i < 7) ? 10'(l) : 10'd700, d, lat);
      tests++; if (lat !== 66 * ((l + 576) / 512)) begin
        fails++; $display("FAIL mb_latency len=%0d: got %0d want %0d", l, lat, 66 * ((l + 576) / 512)); end
      tests++; if (d !== exp) begin fails++; $display("FAIL mb_digest len=%0d: got %h want %h", l, d, exp); end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    @(posedge clk); #1;
    test_known();
    test_random();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_multiblock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
